// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and helpers for the 16x2 character LCD line writer.
package lcd_pkg;

    localparam logic [7:0] LCD_FUNC_SET = 8'h28;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_ROW1     = 8'h80;
    localparam logic [7:0] LCD_ROW2     = 8'hC0;

    localparam int unsigned WAIT_W = 20;
    localparam int unsigned NW_CNT_W = 16;

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT_N,
        CFG,
        ROW1_ADDR,
        ROW1_CHAR,
        ROW2_ADDR,
        ROW2_CHAR
    } lcd_state_t;

    typedef enum logic [1:0] {
        PH_ISSUE,
        PH_BUSY,
        PH_WAIT
    } lcd_phase_t;

    typedef enum logic [2:0] {
        NW_IDLE,
        NW_SETUP,
        NW_E_HIGH,
        NW_HOLD,
        NW_GAP
    } nw_state_t;

    // Column 0 lives in the top byte, so the byte offset is (15 - col) = ~col.
    function automatic logic [7:0] char_at(input logic [127:0] line, input logic [3:0] col);
        return line[{~col, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/lcd_line_writer_if.sv
// Write-only 4-bit HD44780 bus between the line writer and the display.
interface lcd_line_writer_if;

    logic [3:0] lcd_data_out;
    logic       lcd_rs_out;
    logic       lcd_rw_out;
    logic       lcd_e_out;

    modport master (
        output lcd_data_out,
        output lcd_rs_out,
        output lcd_rw_out,
        output lcd_e_out
    );

    modport slave (
        input lcd_data_out,
        input lcd_rs_out,
        input lcd_rw_out,
        input lcd_e_out
    );

endinterface

// File: rtl/lcd_line_writer_nibble.sv
// Strobes one nibble or a full byte (high then low nibble) onto the LCD bus with
// setup, enable-high and inter-nibble gap timing; pulses done when the last nibble is out.
module lcd_nibble_writer
    import lcd_pkg::*;
#(
    parameter int unsigned T_E_HIGH     = 12,
    parameter int unsigned T_SETUP      = 2,
    parameter int unsigned T_NIBBLE_GAP = 50
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       start,
    input  logic       nibble_only,
    input  logic       rs,
    input  logic [7:0] wr_byte,
    output logic       busy,
    output logic       done,
    output logic [3:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_e
);

    localparam logic [NW_CNT_W-1:0] SETUP_LAST = NW_CNT_W'(T_SETUP - 1);
    localparam logic [NW_CNT_W-1:0] E_LAST     = NW_CNT_W'(T_E_HIGH - 1);
    localparam logic [NW_CNT_W-1:0] GAP_LAST   = NW_CNT_W'(T_NIBBLE_GAP - 1);

    nw_state_t             state, state_d;
    logic [NW_CNT_W-1:0]   cnt, cnt_d;
    logic [3:0]            data_d, low_q, low_d;
    logic                  rs_d, e_d, last_q, last_d, done_d;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state    <= NW_IDLE;
            cnt      <= '0;
            lcd_data <= '0;
            lcd_rs   <= 1'b0;
            lcd_e    <= 1'b0;
            low_q    <= '0;
            last_q   <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            lcd_data <= data_d;
            lcd_rs   <= rs_d;
            lcd_e    <= e_d;
            low_q    <= low_d;
            last_q   <= last_d;
            done     <= done_d;
        end
    end

    // HOLD keeps RS/data on the bus for one cycle after E falls.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        data_d  = lcd_data;
        rs_d    = lcd_rs;
        e_d     = lcd_e;
        low_d   = low_q;
        last_d  = last_q;
        done_d  = 1'b0;
        unique case (state)
            NW_IDLE: begin
                if (start) begin
                    data_d  = wr_byte[7:4];
                    low_d   = wr_byte[3:0];
                    rs_d    = rs;
                    last_d  = nibble_only;
                    cnt_d   = '0;
                    state_d = NW_SETUP;
                end
            end
            NW_SETUP: begin
                if (cnt == SETUP_LAST) begin
                    cnt_d   = '0;
                    e_d     = 1'b1;
                    state_d = NW_E_HIGH;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            NW_E_HIGH: begin
                if (cnt == E_LAST) begin
                    cnt_d   = '0;
                    e_d     = 1'b0;
                    state_d = NW_HOLD;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            NW_HOLD: begin
                cnt_d = '0;
                if (last_q) begin
                    done_d  = 1'b1;
                    state_d = NW_IDLE;
                end else begin
                    state_d = NW_GAP;
                end
            end
            NW_GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_d   = '0;
                    data_d  = low_q;
                    last_d  = 1'b1;
                    state_d = NW_SETUP;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: state_d = NW_IDLE;
        endcase
    end

    assign busy = (state != NW_IDLE);

endmodule

// File: rtl/lcd_line_writer.sv
// Runs the HD44780 4-bit init sequence once, then refreshes both rows forever from
// per-frame snapshots of the input lines so a frame never tears.
module lcd_line_writer
    import lcd_pkg::*;
#(
    parameter int unsigned T_POWERUP    = 1000000,
    parameter int unsigned T_INIT1      = 205000,
    parameter int unsigned T_INIT2      = 5000,
    parameter int unsigned T_E_HIGH     = 12,
    parameter int unsigned T_SETUP      = 2,
    parameter int unsigned T_NIBBLE_GAP = 50,
    parameter int unsigned T_CMD_WAIT   = 2000,
    parameter int unsigned T_CLEAR_WAIT = 82000
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [127:0]             line1_in,
    input  logic [127:0]             line2_in,
    lcd_line_writer_if.master        lcd,
    output logic                     init_done_out,
    output logic                     frame_done_out
);

    localparam logic [WAIT_W-1:0] POWERUP_LAST = WAIT_W'(T_POWERUP - 1);
    localparam logic [WAIT_W-1:0] INIT1_LAST   = WAIT_W'(T_INIT1 - 1);
    localparam logic [WAIT_W-1:0] INIT2_LAST   = WAIT_W'(T_INIT2 - 1);
    localparam logic [WAIT_W-1:0] CMD_LAST     = WAIT_W'(T_CMD_WAIT - 1);
    localparam logic [WAIT_W-1:0] CLEAR_LAST   = WAIT_W'(T_CLEAR_WAIT - 1);
    localparam logic [127:0]      BLANK_LINE   = {16{8'h20}};

    lcd_state_t        state, state_d;
    lcd_phase_t        phase, phase_d;
    logic [1:0]        step, step_d;
    logic [3:0]        col, col_d;
    logic [WAIT_W-1:0] wait_cnt, wait_d, wait_last;
    logic [127:0]      snap1, snap1_d, snap2, snap2_d;
    logic              init_done_d, frame_done_d, advance;

    logic [7:0]        cur_byte;
    logic              cur_rs, cur_nib;
    logic              nw_start, nw_busy, nw_done;
    logic [3:0]        nw_data;
    logic              nw_rs, nw_e;

    lcd_nibble_writer #(
        .T_E_HIGH     (T_E_HIGH),
        .T_SETUP      (T_SETUP),
        .T_NIBBLE_GAP (T_NIBBLE_GAP)
    ) u_nibble (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .start       (nw_start),
        .nibble_only (cur_nib),
        .rs          (cur_rs),
        .wr_byte     (cur_byte),
        .busy        (nw_busy),
        .done        (nw_done),
        .lcd_data    (nw_data),
        .lcd_rs      (nw_rs),
        .lcd_e       (nw_e)
    );

    assign lcd.lcd_data_out = nw_data;
    assign lcd.lcd_rs_out   = nw_rs;
    assign lcd.lcd_rw_out   = 1'b0;
    assign lcd.lcd_e_out    = nw_e;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state          <= PWR_WAIT;
            phase          <= PH_ISSUE;
            step           <= '0;
            col            <= '0;
            wait_cnt       <= '0;
            snap1          <= BLANK_LINE;
            snap2          <= BLANK_LINE;
            init_done_out  <= 1'b0;
            frame_done_out <= 1'b0;
        end else begin
            state          <= state_d;
            phase          <= phase_d;
            step           <= step_d;
            col            <= col_d;
            wait_cnt       <= wait_d;
            snap1          <= snap1_d;
            snap2          <= snap2_d;
            init_done_out  <= init_done_d;
            frame_done_out <= frame_done_d;
        end
    end

    // Init nibbles ride in the high half of cur_byte; the writer sends only that half.
    always_comb begin
        cur_byte = 8'h00;
        cur_rs   = 1'b0;
        cur_nib  = 1'b0;
        case (state)
            INIT_N: begin
                cur_byte = (step == 2'd3) ? 8'h20 : 8'h30;
                cur_nib  = 1'b1;
            end
            CFG: begin
                case (step)
                    2'd0:    cur_byte = LCD_FUNC_SET;
                    2'd1:    cur_byte = LCD_ENTRY;
                    2'd2:    cur_byte = LCD_DISP_ON;
                    default: cur_byte = LCD_CLEAR;
                endcase
            end
            ROW1_ADDR: cur_byte = LCD_ROW1;
            ROW1_CHAR: begin
                cur_byte = char_at(snap1, col);
                cur_rs   = 1'b1;
            end
            ROW2_ADDR: cur_byte = LCD_ROW2;
            ROW2_CHAR: begin
                cur_byte = char_at(snap2, col);
                cur_rs   = 1'b1;
            end
            default: ;
        endcase

        wait_last = CMD_LAST;
        if (state == INIT_N && step == 2'd0) begin
            wait_last = INIT1_LAST;
        end else if (state == INIT_N && step == 2'd1) begin
            wait_last = INIT2_LAST;
        end else if (!cur_nib && !cur_rs && cur_byte == LCD_CLEAR) begin
            wait_last = CLEAR_LAST;
        end
    end

    always_comb begin
        state_d      = state;
        phase_d      = phase;
        step_d       = step;
        col_d        = col;
        wait_d       = wait_cnt;
        snap1_d      = snap1;
        snap2_d      = snap2;
        init_done_d  = init_done_out;
        frame_done_d = 1'b0;
        nw_start     = 1'b0;
        advance      = 1'b0;

        if (state == PWR_WAIT) begin
            if (wait_cnt == POWERUP_LAST) begin
                wait_d  = '0;
                state_d = INIT_N;
                step_d  = '0;
                phase_d = PH_ISSUE;
            end else begin
                wait_d = wait_cnt + 1'b1;
            end
        end else begin
            unique case (phase)
                PH_ISSUE: begin
                    if (!nw_busy) begin
                        nw_start = 1'b1;
                        phase_d  = PH_BUSY;
                    end
                end
                PH_BUSY: begin
                    if (nw_done) begin
                        wait_d  = '0;
                        phase_d = PH_WAIT;
                    end
                end
                PH_WAIT: begin
                    if (wait_cnt == wait_last) begin
                        wait_d  = '0;
                        advance = 1'b1;
                        phase_d = PH_ISSUE;
                    end else begin
                        wait_d = wait_cnt + 1'b1;
                    end
                end
                default: phase_d = PH_ISSUE;
            endcase
        end

        // Snapshots are taken on every entry to ROW1_ADDR, from CFG or from the end of a frame.
        if (advance) begin
            case (state)
                INIT_N: begin
                    step_d = step + 2'd1;
                    if (step == 2'd3) begin
                        state_d = CFG;
                    end
                end
                CFG: begin
                    step_d = step + 2'd1;
                    if (step == 2'd3) begin
                        state_d     = ROW1_ADDR;
                        init_done_d = 1'b1;
                        snap1_d     = line1_in;
                        snap2_d     = line2_in;
                    end
                end
                ROW1_ADDR: begin
                    state_d = ROW1_CHAR;
                    col_d   = '0;
                end
                ROW1_CHAR: begin
                    col_d = col + 4'd1;
                    if (col == 4'hF) begin
                        state_d = ROW2_ADDR;
                    end
                end
                ROW2_ADDR: state_d = ROW2_CHAR;
                ROW2_CHAR: begin
                    col_d = col + 4'd1;
                    if (col == 4'hF) begin
                        state_d      = ROW1_ADDR;
                        frame_done_d = 1'b1;
                        snap1_d      = line1_in;
                        snap2_d      = line2_in;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_line_writer.sv
// Randomised bench: decodes the LCD bus on E falling edges and compares against a
// frame model built from the line contents plus timing windows derived from the wait parameters.
module tb_lcd_line_writer;

    localparam int P_POWERUP = 20;
    localparam int P_INIT1   = 30;
    localparam int P_INIT2   = 10;
    localparam int P_E_HIGH  = 3;
    localparam int P_SETUP   = 2;
    localparam int P_GAP     = 4;
    localparam int P_CMD     = 8;
    localparam int P_CLEAR   = 40;
    localparam int TIMEOUT   = 3000;

    localparam logic [127:0] SPACES = {16{8'h20}};
    localparam logic [127:0] ARROWS = {{14{8'h20}}, 8'h3E, 8'h3C};
    localparam logic [127:0] GAME   = "  Game  Over    ";

    typedef struct {
        logic       rs;
        logic [3:0] d;
        int         rise;
        int         fall;
        int         setup;
        logic       stable;
    } nib_t;

    typedef struct {
        int start;
        int width;
    } fd_t;

    logic         clk_in = 1'b0;
    logic         rst_in = 1'b0;
    logic [127:0] line1_in;
    logic [127:0] line2_in;
    logic         init_done_out;
    logic         frame_done_out;

    lcd_line_writer_if lcd ();

    lcd_line_writer #(
        .T_POWERUP    (P_POWERUP),
        .T_INIT1      (P_INIT1),
        .T_INIT2      (P_INIT2),
        .T_E_HIGH     (P_E_HIGH),
        .T_SETUP      (P_SETUP),
        .T_NIBBLE_GAP (P_GAP),
        .T_CMD_WAIT   (P_CMD),
        .T_CLEAR_WAIT (P_CLEAR)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .line1_in       (line1_in),
        .line2_in       (line2_in),
        .lcd            (lcd),
        .init_done_out  (init_done_out),
        .frame_done_out (frame_done_out)
    );

    always #5 clk_in = ~clk_in;

    int   n_checks = 0;
    int   n_errors = 0;
    nib_t nib_q[$];
    fd_t  fd_q[$];
    int   fd_at[$];
    int   cyc = 0;
    int   last_chg = 0;
    int   rise_c = 0;
    int   setup_c = 0;
    int   init_rise = -1;
    int   fd_start = 0;
    int   last_fall = 0;
    int   need_wait = 0;
    int   frame_no = 0;
    logic prev_e = 1'b0;
    logic prev_id = 1'b0;
    logic prev_fd = 1'b0;
    logic [4:0] prev_bus = '0;
    logic [4:0] rise_bus = '0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_range(input string tag, input int val, input int lo, input int hi);
        check($sformatf("%s value=%0d window=[%0d,%0d]", tag, val, lo, hi),
              (val >= lo && val <= hi), 1'b1);
    endtask

    task automatic stop_on_timeout(input string tag);
        check({"timeout ", tag}, 1'b0, 1'b1);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "bench stopped: no activity within bound");
    endtask

    // Bus monitor: one record per E strobe, one per frame_done pulse.
    always @(negedge clk_in) begin
        logic [4:0] bus;
        nib_t       item;
        fd_t        fdi;
        cyc++;
        bus = {lcd.lcd_rs_out, lcd.lcd_data_out};
        if (bus != prev_bus) last_chg = cyc;
        if (lcd.lcd_e_out && !prev_e) begin
            rise_c   = cyc;
            rise_bus = bus;
            setup_c  = cyc - last_chg;
        end
        if (!lcd.lcd_e_out && prev_e && rst_in) begin
            item.rs     = bus[4];
            item.d      = bus[3:0];
            item.rise   = rise_c;
            item.fall   = cyc;
            item.setup  = setup_c;
            item.stable = (bus == rise_bus);
            nib_q.push_back(item);
        end
        if (init_done_out && !prev_id) init_rise = cyc;
        if (frame_done_out && !prev_fd) fd_start = cyc;
        if (!frame_done_out && prev_fd && rst_in) begin
            fdi.start = fd_start;
            fdi.width = cyc - fd_start;
            fd_q.push_back(fdi);
        end
        prev_e   = lcd.lcd_e_out;
        prev_id  = init_done_out;
        prev_fd  = frame_done_out;
        prev_bus = bus;
    end

    function automatic logic [127:0] rnd_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Expected {rs, byte} of write k in a frame: address, 16 chars, address, 16 chars.
    function automatic logic [8:0] frame_item(input logic [127:0] l1, input logic [127:0] l2,
                                              input int k);
        logic [127:0] l;
        int           c;
        if (k == 0) return {1'b0, 8'h80};
        if (k == 17) return {1'b0, 8'hC0};
        l = (k < 17) ? l1 : l2;
        c = (k < 17) ? k - 1 : k - 18;
        l = l >> (8 * (15 - c));
        return {1'b1, l[7:0]};
    endfunction

    task automatic get_nib(output nib_t n);
        int t = 0;
        while (nib_q.size() == 0 && t < TIMEOUT) begin
            @(negedge clk_in);
            t++;
        end
        if (nib_q.size() == 0) stop_on_timeout("waiting for E strobe");
        n = nib_q.pop_front();
        check($sformatf("e_width at %0d", n.fall), n.fall - n.rise, P_E_HIGH);
        check_range("setup_before_e", n.setup, P_SETUP, TIMEOUT);
        check($sformatf("bus_stable_through_e at %0d", n.fall), n.stable, 1'b1);
    endtask

    task automatic check_wait(input int rise);
        check_range("post_write_wait", rise - last_fall, need_wait, need_wait + P_SETUP + 4);
    endtask

    task automatic get_byte(output logic rs, output logic [7:0] b);
        nib_t hi, lo;
        get_nib(hi);
        check_wait(hi.rise);
        get_nib(lo);
        check_range("nibble_gap", lo.rise - hi.fall, P_GAP, P_GAP + P_SETUP + 3);
        check("rs_same_both_nibbles", lo.rs, hi.rs);
        rs        = hi.rs;
        b         = {hi.d, lo.d};
        last_fall = lo.fall;
    endtask

    task automatic run_init();
        nib_t       n;
        int         rel;
        int         t;
        logic       rs;
        logic [7:0] b;
        logic [3:0] init_nib[4]  = '{4'h3, 4'h3, 4'h3, 4'h2};
        int         init_wait[4] = '{P_INIT1, P_INIT2, P_CMD, P_CMD};
        logic [7:0] cfg[4]       = '{8'h28, 8'h06, 8'h0C, 8'h01};
        rel    = cyc;
        rst_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            get_nib(n);
            if (i == 0) check_range("powerup_delay", n.rise - rel, P_POWERUP + P_SETUP,
                                    P_POWERUP + P_SETUP + 4);
            else check_wait(n.rise);
            check($sformatf("init_nibble %0d", i), {n.rs, n.d}, {1'b0, init_nib[i]});
            last_fall = n.fall;
            need_wait = init_wait[i];
        end
        for (int i = 0; i < 4; i++) begin
            get_byte(rs, b);
            check($sformatf("cfg_byte %0d", i), {rs, b}, {1'b0, cfg[i]});
            need_wait = (cfg[i] == 8'h01) ? P_CLEAR : P_CMD;
        end
        check("init_done_low_during_clear_wait", init_done_out, 1'b0);
        t = 0;
        while (init_rise < 0 && t < TIMEOUT) begin
            @(negedge clk_in);
            t++;
        end
        if (init_rise < 0) stop_on_timeout("waiting for init_done_out");
        check_range("init_done_after_clear_wait", init_rise - last_fall, P_CLEAR, P_CLEAR + 4);
    endtask

    task automatic run_frame(input logic [127:0] l1, input logic [127:0] l2, input logic change,
                             input logic [127:0] n1, input logic [127:0] n2);
        logic       rs;
        logic [7:0] b;
        logic [8:0] exp;
        fd_t        fd;
        int         t;
        for (int k = 0; k < 34; k++) begin
            get_byte(rs, b);
            exp = frame_item(l1, l2, k);
            check($sformatf("frame %0d write %0d", frame_no, k), {rs, b}, exp);
            need_wait = (exp == 9'h001) ? P_CLEAR : P_CMD;
            if (change && k == 6) begin
                line1_in = n1;
                line2_in = n2;
            end
        end
        t = 0;
        while (fd_q.size() == 0 && t < TIMEOUT) begin
            @(negedge clk_in);
            t++;
        end
        if (fd_q.size() == 0) stop_on_timeout("waiting for frame_done_out");
        fd = fd_q.pop_front();
        check($sformatf("frame_done_width frame %0d", frame_no), fd.width, 1);
        check_range("frame_done_after_last_wait", fd.start - last_fall, P_CMD, P_CMD + 4);
        check($sformatf("single_frame_done frame %0d", frame_no), fd_q.size(), 0);
        fd_at.push_back(fd.start);
        frame_no++;
    endtask

    initial begin
        logic [127:0] cur1, cur2, new1, new2;
        int           base, d0, d, t;

        line1_in = ARROWS;
        line2_in = SPACES;
        rst_in   = 1'b0;
        repeat (5) @(negedge clk_in);
        check("reset_data", lcd.lcd_data_out, 4'h0);
        check("reset_rs", lcd.lcd_rs_out, 1'b0);
        check("reset_rw", lcd.lcd_rw_out, 1'b0);
        check("reset_e", lcd.lcd_e_out, 1'b0);
        check("reset_init_done", init_done_out, 1'b0);
        check("reset_frame_done", frame_done_out, 1'b0);

        run_init();
        run_frame(ARROWS, SPACES, 1'b1, GAME, SPACES);
        cur1 = GAME;
        cur2 = SPACES;
        for (int f = 0; f < 3; f++) begin
            new1 = rnd_line();
            new2 = rnd_line();
            run_frame(cur1, cur2, 1'b1, new1, new2);
            cur1 = new1;
            cur2 = new2;
        end
        check("rw_held_low", lcd.lcd_rw_out, 1'b0);

        base = 34 * (2 * (P_SETUP + P_E_HIGH + 1) + P_GAP + P_CMD);
        d0   = fd_at[1] - fd_at[0];
        for (int i = 1; i < 4; i++) begin
            d = fd_at[i] - fd_at[i - 1];
            check_range($sformatf("frame_period %0d", i), d, base, base + 34 * 4);
            if (i > 1) check($sformatf("frame_period_constant %0d", i), d, d0);
        end

        repeat ($urandom_range(50, 400)) @(negedge clk_in);
        t = 0;
        while (!lcd.lcd_e_out && t < TIMEOUT) begin
            @(negedge clk_in);
            t++;
        end
        check("e_high_before_midframe_reset", lcd.lcd_e_out, 1'b1);
        cur1     = rnd_line();
        cur2     = rnd_line();
        line1_in = cur1;
        line2_in = cur2;
        rst_in   = 1'b0;
        @(negedge clk_in);
        check("midreset_e", lcd.lcd_e_out, 1'b0);
        check("midreset_init_done", init_done_out, 1'b0);
        check("midreset_frame_done", frame_done_out, 1'b0);
        check("midreset_data", lcd.lcd_data_out, 4'h0);
        check("midreset_rs", lcd.lcd_rs_out, 1'b0);
        repeat (2) @(negedge clk_in);
        nib_q.delete();
        fd_q.delete();
        init_rise = -1;
        run_init();
        run_frame(cur1, cur2, 1'b0, cur1, cur2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
